// File: rtl/arm_defs.sv
// arm_defs: shared ALU opcodes, shift types, NZCV bit positions and the EXE/MEM record
package arm_defs;
  localparam int DATA_W = 32;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;
  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;
  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] val_rm;
    logic [3:0]        dest;
  } exe_mem_t;
endpackage

// File: rtl/exe_stage_if.sv
// exe_stage_if: ID/EXE inputs and EXE/MEM outputs of the execute stage
interface exe_stage_if;
  import arm_defs::*;
  logic              freeze;
  logic              WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, imm_IN;
  logic [3:0]        EXE_CMD_IN, Dest_IN, Status_in;
  logic [DATA_W-1:0] PC_IN, Val_Rn_IN, Val_Rm_IN;
  logic [11:0]       Shift_operand_IN;
  logic [23:0]       Signed_imm_24_IN;
  logic              Branch_Taken, WB_EN, MEM_R_EN, MEM_W_EN;
  logic [DATA_W-1:0] Branch_Address, ALU_Res, Val_Rm;
  logic [3:0]        Status, Dest;
  modport master (
    output freeze, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, imm_IN, EXE_CMD_IN,
           Dest_IN, Status_in, PC_IN, Val_Rn_IN, Val_Rm_IN, Shift_operand_IN, Signed_imm_24_IN,
    input  Branch_Taken, WB_EN, MEM_R_EN, MEM_W_EN, Branch_Address, ALU_Res, Val_Rm, Status, Dest
  );
  modport slave (
    input  freeze, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, imm_IN, EXE_CMD_IN,
           Dest_IN, Status_in, PC_IN, Val_Rn_IN, Val_Rm_IN, Shift_operand_IN, Signed_imm_24_IN,
    output Branch_Taken, WB_EN, MEM_R_EN, MEM_W_EN, Branch_Address, ALU_Res, Val_Rm, Status, Dest
  );
endinterface

// File: rtl/exe_stage_alu.sv
// alu: arithmetic/logical result and NZCV; unknown opcodes return 0 and pass flags through
module alu
  import arm_defs::*;
(
  input  logic [3:0]        cmd_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [3:0]        status_i,
  output logic [DATA_W-1:0] res_o,
  output logic [3:0]        nzcv_o
);
  logic              is_sub, is_arith, is_logic, cin;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;
  logic              c, v;
  always_comb begin
    is_sub   = cmd_i == CMD_SUB || cmd_i == CMD_SBC;
    is_arith = is_sub || cmd_i == CMD_ADD || cmd_i == CMD_ADC;
    is_logic = cmd_i == CMD_MOV || cmd_i == CMD_MVN || cmd_i == CMD_AND ||
               cmd_i == CMD_ORR || cmd_i == CMD_EOR;
    // Subtraction is A + ~B + carry, so carry-out is the inverted borrow
    b_eff    = is_sub ? ~b_i : b_i;
    cin      = (cmd_i == CMD_ADC || cmd_i == CMD_SBC) ? status_i[C_BIT] : is_sub;
    sum      = {1'b0, a_i} + {1'b0, b_eff} + {32'b0, cin};
    res_o    = cmd_i == CMD_MOV ? b_i :
               cmd_i == CMD_MVN ? ~b_i :
               is_arith         ? sum[DATA_W-1:0] :
               cmd_i == CMD_AND ? a_i & b_i :
               cmd_i == CMD_ORR ? a_i | b_i :
               cmd_i == CMD_EOR ? a_i ^ b_i : '0;
    c        = is_arith ? sum[DATA_W] : status_i[C_BIT];
    v        = is_arith ? (a_i[31] == b_eff[31]) && (sum[31] != a_i[31]) : status_i[V_BIT];
    nzcv_o   = (is_arith || is_logic) ? {res_o[31], res_o == '0, c, v} : status_i;
  end
endmodule

// File: rtl/exe_stage_val2.sv
// val2_generator: second ALU operand from memory offset, rotated immediate or shifted register
module val2_generator
  import arm_defs::*;
(
  input  logic              mem_en_i,
  input  logic              imm_i,
  input  logic [11:0]       so_i,
  input  logic [DATA_W-1:0] rm_i,
  output logic [DATA_W-1:0] val2_o
);
  logic [4:0]        amt;
  logic [DATA_W-1:0] imm_rot, rm_rot, rm_asr, rm_sh;
  assign amt = so_i[11:7];
  // Rotates are done as a right shift of the value concatenated with itself
  assign imm_rot = 32'({2{24'b0, so_i[7:0]}} >> {so_i[11:8], 1'b0});
  assign rm_rot  = 32'({2{rm_i}} >> amt);
  assign rm_asr  = $signed(rm_i) >>> amt;
  always_comb begin
    rm_sh  = so_i[6:5] == SH_LSL ? rm_i << amt :
             so_i[6:5] == SH_LSR ? rm_i >> amt :
             so_i[6:5] == SH_ASR ? rm_asr : rm_rot;
    val2_o = mem_en_i ? {20'b0, so_i} : imm_i ? imm_rot : rm_sh;
  end
endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute stage with operand generation, ALU, branch target, CPSR and EXE/MEM register
module exe_stage
  import arm_defs::*;
(
  input logic        clk,
  input logic        rst,
  exe_stage_if.slave bus
);
  logic [DATA_W-1:0] val2, alu_res;
  logic [3:0]        alu_nzcv, status_d, status_q;
  exe_mem_t          exe_mem_d, exe_mem_q;
  val2_generator u_val2 (
    .mem_en_i (bus.MEM_R_EN_IN | bus.MEM_W_EN_IN),
    .imm_i    (bus.imm_IN),
    .so_i     (bus.Shift_operand_IN),
    .rm_i     (bus.Val_Rm_IN),
    .val2_o   (val2)
  );
  alu u_alu (
    .cmd_i    (bus.EXE_CMD_IN),
    .a_i      (bus.Val_Rn_IN),
    .b_i      (val2),
    .status_i (bus.Status_in),
    .res_o    (alu_res),
    .nzcv_o   (alu_nzcv)
  );
  assign bus.Branch_Taken   = bus.B_IN;
  assign bus.Branch_Address = bus.PC_IN + {{6{bus.Signed_imm_24_IN[23]}}, bus.Signed_imm_24_IN, 2'b00};
  always_comb begin
    status_d  = bus.S_IN ? alu_nzcv : status_q;
    exe_mem_d = '{wb_en: bus.WB_EN_IN, mem_r_en: bus.MEM_R_EN_IN, mem_w_en: bus.MEM_W_EN_IN,
                  alu_res: alu_res, val_rm: bus.Val_Rm_IN, dest: bus.Dest_IN};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_mem_q <= '0;
      status_q  <= '0;
    end else if (!bus.freeze) begin
      exe_mem_q <= exe_mem_d;
      status_q  <= status_d;
    end
  end
  assign bus.Status   = status_q;
  assign bus.WB_EN    = exe_mem_q.wb_en;
  assign bus.MEM_R_EN = exe_mem_q.mem_r_en;
  assign bus.MEM_W_EN = exe_mem_q.mem_w_en;
  assign bus.ALU_Res  = exe_mem_q.alu_res;
  assign bus.Val_Rm   = exe_mem_q.val_rm;
  assign bus.Dest     = exe_mem_q.dest;
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed vectors with hand-computed results for the execute stage
module tb_exe_stage;
  logic clk = 0;
  logic rst;
  int   errs = 0;
  int   checks = 0;
  exe_stage_if bus();
  exe_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.freeze = 0; bus.WB_EN_IN = 0; bus.MEM_R_EN_IN = 0; bus.MEM_W_EN_IN = 0;
    bus.B_IN = 0; bus.S_IN = 0; bus.imm_IN = 0; bus.EXE_CMD_IN = 0; bus.Dest_IN = 0;
    bus.Status_in = 0; bus.PC_IN = 0; bus.Val_Rn_IN = 0; bus.Val_Rm_IN = 0;
    bus.Shift_operand_IN = 0; bus.Signed_imm_24_IN = 0;
  endtask
  task automatic op(input logic [3:0] cmd, input logic s, input logic imm, input logic [11:0] so,
                    input logic [31:0] rn, input logic [31:0] rm, input logic [3:0] sin);
    idle();
    bus.WB_EN_IN = 1; bus.Dest_IN = 4'd1;
    bus.EXE_CMD_IN = cmd; bus.S_IN = s; bus.imm_IN = imm; bus.Shift_operand_IN = so;
    bus.Val_Rn_IN = rn; bus.Val_Rm_IN = rm; bus.Status_in = sin;
  endtask
  initial begin
    idle();
    rst = 1;
    step();
    chk("rst_res", bus.ALU_Res, 0);
    chk("rst_status", {28'b0, bus.Status}, 0);
    chk("rst_wb", {31'b0, bus.WB_EN}, 0);
    rst = 0;
    op(4'b0010, 1, 1, 12'h001, 32'hFFFFFFFF, 0, 4'b0000); bus.Dest_IN = 4'd3;
    step();
    chk("add_wrap_res", bus.ALU_Res, 0);
    chk("add_wrap_st", {28'b0, bus.Status}, 32'h6);
    chk("add_wb", {31'b0, bus.WB_EN}, 1);
    chk("add_dest", {28'b0, bus.Dest}, 3);
    op(4'b0100, 1, 0, 12'h000, 5, 7, 4'b0110);
    step();
    chk("cmp_res", bus.ALU_Res, 32'hFFFFFFFE);
    chk("cmp_st", {28'b0, bus.Status}, 32'h8);
    op(4'b0100, 0, 0, 12'h000, 9, 7, 4'b0110);
    step();
    chk("sub_nos_res", bus.ALU_Res, 2);
    chk("sub_nos_st", {28'b0, bus.Status}, 32'h8);
    op(4'b0001, 0, 1, 12'h4FF, 0, 0, 0);
    step();
    chk("mov_imm_rot", bus.ALU_Res, 32'hFF000000);
    op(4'b0001, 0, 0, 12'h240, 0, 32'h80000000, 0);
    step();
    chk("mov_asr", bus.ALU_Res, 32'hF8000000);
    op(4'b0001, 0, 0, 12'h220, 0, 32'h80000000, 0);
    step();
    chk("mov_lsr", bus.ALU_Res, 32'h08000000);
    op(4'b0001, 0, 0, 12'h260, 0, 32'h0000000F, 0);
    step();
    chk("mov_ror", bus.ALU_Res, 32'hF0000000);
    op(4'b0001, 0, 0, 12'h200, 0, 32'h00000001, 0);
    step();
    chk("mov_lsl", bus.ALU_Res, 32'h10);
    op(4'b0010, 0, 0, 12'h004, 32'h100, 0, 0); bus.MEM_R_EN_IN = 1; bus.Dest_IN = 4'd5;
    step();
    chk("ldr_addr", bus.ALU_Res, 32'h104);
    chk("ldr_mr", {31'b0, bus.MEM_R_EN}, 1);
    chk("ldr_mw", {31'b0, bus.MEM_W_EN}, 0);
    chk("ldr_dest", {28'b0, bus.Dest}, 5);
    op(4'b0010, 0, 1, 12'h4FF, 32'h100, 32'hDEADBEEF, 0); bus.MEM_W_EN_IN = 1; bus.WB_EN_IN = 0;
    step();
    chk("str_addr", bus.ALU_Res, 32'h5FF);
    chk("str_data", bus.Val_Rm, 32'hDEADBEEF);
    chk("str_mw", {31'b0, bus.MEM_W_EN}, 1);
    chk("str_wb", {31'b0, bus.WB_EN}, 0);
    idle(); bus.B_IN = 1; bus.PC_IN = 32'h20; bus.Signed_imm_24_IN = 24'hFFFFFE;
    #1;
    chk("br_taken", {31'b0, bus.Branch_Taken}, 1);
    chk("br_back", bus.Branch_Address, 32'h18);
    bus.PC_IN = 32'h100; bus.Signed_imm_24_IN = 24'h000004;
    #1;
    chk("br_fwd", bus.Branch_Address, 32'h110);
    op(4'b0011, 1, 1, 12'h001, 1, 0, 4'b0010);
    step();
    chk("adc_res", bus.ALU_Res, 3);
    chk("adc_st", {28'b0, bus.Status}, 0);
    op(4'b0010, 1, 1, 12'h001, 32'h7FFFFFFF, 0, 0);
    step();
    chk("ovf_res", bus.ALU_Res, 32'h80000000);
    chk("ovf_st", {28'b0, bus.Status}, 32'h9);
    op(4'b0101, 1, 1, 12'h002, 5, 0, 4'b0000);
    step();
    chk("sbc_res", bus.ALU_Res, 2);
    chk("sbc_st", {28'b0, bus.Status}, 32'h2);
    op(4'b0110, 1, 1, 12'h0FF, 32'hF0, 0, 4'b0011);
    step();
    chk("and_res", bus.ALU_Res, 32'hF0);
    chk("and_st", {28'b0, bus.Status}, 32'h3);
    op(4'b1000, 1, 1, 12'h0FF, 32'hFF, 0, 4'b0000);
    step();
    chk("eor_res", bus.ALU_Res, 0);
    chk("eor_st", {28'b0, bus.Status}, 32'h4);
    op(4'b1001, 1, 1, 12'h000, 0, 0, 4'b0000);
    step();
    chk("mvn_res", bus.ALU_Res, 32'hFFFFFFFF);
    chk("mvn_st", {28'b0, bus.Status}, 32'h8);
    op(4'b0111, 0, 1, 12'h00F, 32'hF00, 0, 0);
    step();
    chk("orr_res", bus.ALU_Res, 32'hF0F);
    op(4'b0000, 1, 1, 12'h001, 32'h1234, 0, 4'b1000);
    step();
    chk("nop_res", bus.ALU_Res, 0);
    chk("nop_st", {28'b0, bus.Status}, 32'h8);
    op(4'b0010, 1, 1, 12'h001, 1, 0, 0); bus.Dest_IN = 4'd9;
    step();
    chk("pre_frz_res", bus.ALU_Res, 2);
    chk("pre_frz_st", {28'b0, bus.Status}, 0);
    op(4'b0100, 1, 1, 12'h001, 0, 0, 0); bus.Dest_IN = 4'd4; bus.freeze = 1;
    step();
    chk("frz1_res", bus.ALU_Res, 2);
    chk("frz1_st", {28'b0, bus.Status}, 0);
    bus.Val_Rn_IN = 10;
    step();
    chk("frz2_res", bus.ALU_Res, 2);
    chk("frz2_dest", {28'b0, bus.Dest}, 9);
    bus.freeze = 0;
    step();
    chk("unfrz_res", bus.ALU_Res, 9);
    chk("unfrz_st", {28'b0, bus.Status}, 32'h2);
    bus.freeze = 1; rst = 1;
    step();
    chk("frz_rst_res", bus.ALU_Res, 0);
    chk("frz_rst_st", {28'b0, bus.Status}, 0);
    chk("frz_rst_dest", {28'b0, bus.Dest}, 0);
    rst = 0;
    op(4'b0010, 1, 1, 12'h001, 4, 0, 0); bus.Dest_IN = 4'd7;
    step();
    chk("pre_rst_res", bus.ALU_Res, 5);
    #3 rst = 1;
    #1;
    chk("mid_rst_res", bus.ALU_Res, 5);
    chk("mid_rst_wb", {31'b0, bus.WB_EN}, 1);
    step();
    chk("edge_rst_res", bus.ALU_Res, 0);
    chk("edge_rst_wb", {31'b0, bus.WB_EN}, 0);
    chk("edge_rst_dest", {28'b0, bus.Dest}, 0);
    rst = 0;
    op(4'b0010, 0, 1, 12'h003, 4, 0, 0); bus.MEM_R_EN_IN = 1;
    step();
    chk("pre_bub_mr", {31'b0, bus.MEM_R_EN}, 1);
    idle();
    step();
    chk("bub_wb", {31'b0, bus.WB_EN}, 0);
    chk("bub_mr", {31'b0, bus.MEM_R_EN}, 0);
    chk("bub_res", bus.ALU_Res, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline. Consumes the ID/EXE pipeline register outputs and computes Val2 (immediate rotate / register shift / memory offset).
- Runs the ALU, computes the branch target and owns the CPSR flag register (NZCV).
- Registers results into the EXE/MEM pipeline register feeding the memory stage.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- freeze  in  1  hazard stall; holds EXE/MEM register and status register
- WB_EN_IN  in  1  write-back enable
- MEM_R_EN_IN  in  1  load
- MEM_W_EN_IN  in  1  store
- B_IN  in  1  branch, condition already passed in ID
- S_IN  in  1  update flags
- EXE_CMD_IN  in  4  ALU opcode
- PC_IN  in  32  PC+4 of the instruction
- Val_Rn_IN  in  32  first operand
- Val_Rm_IN  in  32  second register value and store data
- imm_IN  in  1  immediate operand select
- Shift_operand_IN  in  12  shifter operand field
- Signed_imm_24_IN  in  24  branch offset
- Dest_IN  in  4  destination register
- Status_in  in  4  NZCV snapshot carried with the instruction
- Branch_Taken  out  1  combinational, equals B_IN
- Branch_Address  out  32  combinational branch target
- Status  out  4  current NZCV register, to ID condition check
- WB_EN, MEM_R_EN, MEM_W_EN  out  1 each  registered controls
- ALU_Res  out  32  registered ALU result or memory address
- Val_Rm  out  32  registered store data
- Dest  out  4  registered destination

Behaviour:
- Reset: synchronous; rst sampled high on a clk edge clears every registered output and Status to 0. rst has priority over freeze. Branch_Taken and Branch_Address follow their inputs combinationally.
- Latency: 1 cycle from ID/EXE outputs to the registered outputs.
- freeze=1: all registered outputs and Status hold their values.
- Val2 selection, in priority order:
  - MEM_R_EN_IN or MEM_W_EN_IN: Val2 = zero-extended Shift_operand_IN[11:0].
  - Else imm_IN: Val2 = {24'b0, so[7:0]} rotated right by 2*so[11:8].
  - Else shift Val_Rm_IN by so[11:7] with type so[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. An amount of 0 gives Val_Rm_IN unchanged.
- ALU operations, with A = Val_Rn_IN and Cin = Status_in[1]:
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD/LDR/STR: A+Val2
  - 0011 ADC: A+Val2+Cin
  - 0100 SUB/CMP: A-Val2
  - 0101 SBC: A-Val2-!Cin
  - 0110 AND/TST: A&Val2
  - 0111 ORR: A|Val2
  - 1000 EOR: A^Val2
  - Other codes: result 0, flags unchanged.
- Flags, in bit order [3]N [2]Z [1]C [0]V:
  - N = res[31]; Z = (res==0).
  - Add ops: C = bit 32 carry-out; V = operands of equal sign and result sign differs.
  - Sub ops: C = NOT borrow (1 when A >= Val2+!Cin unsigned); V = operands of opposite sign and result sign differs from A.
  - Logical ops and MOV/MVN: C and V are copied from Status_in.
- Status register: loads the new NZCV on a clk edge when S_IN && !freeze && !rst; otherwise holds.
- Branch_Address = PC_IN + (sign-extend(Signed_imm_24_IN) << 2), with wrap-around modulo 2^32.
- Register bank: loads all EXE/MEM controls, ALU_Res, Val_Rm_IN and Dest_IN every non-frozen cycle. Bubbles (all controls 0) pass through unchanged.
- Wrap-around: 0xFFFFFFFF+1 gives 0 with C=1 and Z=1. 0x7FFFFFFF+1 gives V=1.

Decomposition:
- Shared package arm_defs:
  - EXE_CMD constants
  - shift-type constants (LSL/LSR/ASR/ROR)
  - NZCV bit indices
- Sub-modules:
  - val2_generator (combinational)
  - alu (combinational, returns result and NZCV)
- exe_stage instantiates both and holds the status register and the EXE/MEM register.

Test Plan:
- ADD with S=1, Rn=0xFFFFFFFF, imm so=0x001 -> next cycle ALU_Res=0, Status=0110 (Z,C).
- SUB (CMP) with S=1, Rn=5, Rm=7, LSL 0 -> ALU_Res=0xFFFFFFFE, Status N=1, C=0, V=0. Repeat with S=0 -> Status unchanged.
- MOV imm so=0x4FF (0xFF ror 8) -> ALU_Res=0xFF000000. Register ASR: so={5'd4,2'b10,...}, Rm=0x80000000 -> 0xF8000000.
- LDR with Rn=0x100, so=0x004 -> ALU_Res=0x104, MEM_R_EN=1, Dest passed through. B=1, PC=0x20, imm24=0xFFFFFE -> Branch_Address=0x18 combinationally.
- freeze=1 for 2 cycles with changing inputs -> outputs and Status hold. freeze=1 together with rst=1 -> all cleared.
- rst asserted between clk edges -> no change until the next edge, then all outputs 0. ADC with Cin=1, Rn=1, Val2=1 -> 3.
